// File: rtl/shared_mem_responder.sv
// Memory-side responder for the shared memory bus: one request at a time, WAIT_STATES wait cycles, one-cycle mem_ready.
// Optional access counters (rd_count/wr_count/cnt_clear) are built when SHMEM_ACCESS_CNT_EN is defined.
module shared_mem_responder #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_read_enable,
  input  logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_ready,
  output logic                  mem_busy
`ifdef SHMEM_ACCESS_CNT_EN
  ,
  input  logic                  cnt_clear,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam bit          NO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0]  WS_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  req;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_wr;

  assign req = mem_read_enable | mem_write_enable;

  // With no wait states the access commits on the accepting edge, straight from the bus;
  // otherwise it commits from the latched request on the last BUSY edge.
  assign commit    = rst_n && (((state_q == BUSY) && (cnt_q == '0)) ||
                               (NO_WAIT && (state_q == IDLE) && req));
  assign acc_addr  = (state_q == IDLE) ? mem_addr         : addr_q;
  assign acc_wdata = (state_q == IDLE) ? mem_write_data   : wdata_q;
  assign acc_wr    = (state_q == IDLE) ? mem_write_enable : wr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = mem_addr;
          wdata_d = mem_write_data;
          wr_d    = mem_write_enable;
          cnt_d   = WS_INIT;
          state_d = NO_WAIT ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (commit) rdata_d = mem_q[acc_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage has no reset; read data is captured from the pre-write contents on the same edge.
  always_ff @(posedge clk) begin
    if (commit && acc_wr) mem_q[acc_addr] <= acc_wdata;
  end

  assign mem_read_data = rdata_q;
  assign mem_ready     = (state_q == RESP);
  assign mem_busy      = (state_q != IDLE);

`ifdef SHMEM_ACCESS_CNT_EN
  logic        rd_q, rd_d;
  logic        acc_rd;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  assign acc_rd = (state_q == IDLE) ? mem_read_enable : rd_q;

  always_comb begin
    rd_d     = rd_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if ((state_q == IDLE) && req) rd_d = mem_read_enable;
    if (cnt_clear) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else if (commit) begin
      if (acc_rd && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 16'd1;
      if (acc_wr && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_q     <= rd_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule
